alu_seq_n: RTL and testbench

- Parametrised, registered successor to the 32-bit single-cycle ALU in the MIPS datapath.
- Supports the same aluCode set: ADD, SUB, AND, OR, SLT.
- Adds NOR, SLTU, a signed-overflow flag, a start/done handshake, and iterative signed MULT/DIV writing HI/LO.
- Sits in EX stage; the controller stalls on busy.

---
 rtl/alu_seq_n_pkg.sv | 21 ++
 rtl/mul_div_iter.sv | 148 ++++++++++++++
 rtl/alu_seq_n.sv | 110 +++++++++++
 tb/tb_alu_seq_n.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_n_pkg.sv
// Shared definitions for the sequential ALU: operation codes and the
// state encoding of the iterative multiply/divide engine.
package alu_defs;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative signed multiply / divide engine. Works on operand magnitudes
// for WIDTH iterations, then applies the sign correction and writes hi/lo.
// A divide by zero completes immediately with err and never goes busy.
module mul_div_iter
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, err_q, err_d;

  // Working registers: acc is the running upper product half or the
  // partial remainder; q holds multiplier bits or quotient bits.
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d;
  logic             div_q, div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum, shifted, sub_diff;

  // Next-state, iteration datapath and completion logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    div_d   = div_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;

    mag_a    = a[WIDTH-1] ? -a : a;
    mag_b    = b[WIDTH-1] ? -b : b;
    add_sum  = {1'b0, acc_q} + {1'b0, m_q};
    shifted  = {acc_q, q_q[WIDTH-1]};
    sub_diff = shifted - {1'b0, m_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_div && (b == '0)) begin
            hi_d   = a;
            lo_d   = '1;
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = ITER;
            cnt_d   = CW'(WIDTH - 1);
            div_d   = op_div;
            neg_a_d = a[WIDTH-1];
            neg_b_d = b[WIDTH-1];
            acc_d   = '0;
            q_d     = mag_a;
            m_d     = mag_b;
          end
        end
      end
      ITER: begin
        if (div_q) begin
          // Restoring step: keep the trial subtraction only if it did not borrow.
          if (!sub_diff[WIDTH]) begin
            acc_d = sub_diff[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = shifted[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Shift-add step: conditionally add, then shift {carry,acc,q} right.
          if (q_q[0]) {acc_d, q_d} = {add_sum, q_q[WIDTH-1:1]};
          else        {acc_d, q_d} = {1'b0, acc_q, q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          lo_d = (neg_a_q ^ neg_b_q) ? -q_q : q_q;
          hi_d = neg_a_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? -{acc_q, q_q} : {acc_q, q_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Working registers, always loaded on accept before being read.
  always_ff @(posedge clk) begin
    // NOTE: these carry no reset; they are fully reloaded on accept, so resetting them would only add logic.
    acc_q   <= acc_d;
    q_q     <= q_d;
    m_q     <= m_d;
    div_q   <= div_d;
    neg_a_q <= neg_a_d;
    neg_b_q <= neg_b_d;
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: rtl/alu_seq_n.sv
// Registered MIPS-style ALU: single-cycle logic/arith/compare ops with
// result/zero/overflow flags, plus an optional iterative MULT/DIV engine
// writing hi/lo, all behind a start/busy/done handshake.
module alu_seq_n
  import alu_defs::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             err
);

  logic             accept, is_muldiv, eng_start;
  logic             eng_busy, eng_done, eng_err;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] sum, diff;

  assign accept    = start & ~eng_busy;
  assign is_muldiv = MULDIV_EN && ((alu_code == ALU_MULT) || (alu_code == ALU_DIV));
  assign eng_start = accept & is_muldiv;

  mul_div_iter #(.WIDTH(WIDTH)) u_mul_div (
    .clk    (clk),
    .reset  (reset),
    .start  (eng_start),
    .op_div (alu_code == ALU_DIV),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo),
    .busy   (eng_busy),
    .done   (eng_done),
    .err    (eng_err)
  );

  // Single-cycle datapath: compute result and flags for an accepted op;
  // MULT/DIV accepts leave result/zero/overflow untouched.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    sum      = a + b;
    diff     = a - b;
    if (accept && !is_muldiv) begin
      done_d = 1'b1;
      ovf_d  = 1'b0;
      case (alu_code)
        ALU_AND:  result_d = a & b;
        ALU_OR:   result_d = a | b;
        ALU_NOR:  result_d = ~(a | b);
        ALU_ADD: begin
          result_d = sum;
          ovf_d    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        ALU_SUB: begin
          result_d = diff;
          ovf_d    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, (a < b)};
        default: begin
          result_d = '0;
          err_d    = 1'b1;
        end
      endcase
      zero_d = (result_d == '0);
    end
  end

  // Result and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign busy     = eng_busy;
  assign done     = done_q | eng_done;
  assign err      = err_q | eng_err;

endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n: a 32-bit instance with MULT/DIV and a
// 16-bit instance without, driven by shared stimulus and compared every
// cycle against a transaction-level arithmetic model.
`timescale 1ns/1ps
module tb_alu_seq_n;
  import alu_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  code = ALU_AND;
  logic [31:0] a_in = '0, b_in = '0;

  logic [31:0] r32, hi32, lo32;
  logic        z32, o32, busy32, done32, err32;
  logic [15:0] r16, hi16, lo16;
  logic        z16, o16, busy16, done16, err16;

  always #5 clk = ~clk;

  alu_seq_n #(.WIDTH(32), .MULDIV_EN(1'b1)) dut32 (
    .clk(clk), .reset(reset), .start(start), .alu_code(code), .a(a_in), .b(b_in),
    .result(r32), .zero(z32), .overflow(o32), .hi(hi32), .lo(lo32),
    .busy(busy32), .done(done32), .err(err32)
  );

  alu_seq_n #(.WIDTH(16), .MULDIV_EN(1'b0)) dut16 (
    .clk(clk), .reset(reset), .start(start), .alu_code(code), .a(a_in[15:0]), .b(b_in[15:0]),
    .result(r16), .zero(z16), .overflow(o16), .hi(hi16), .lo(lo16),
    .busy(busy16), .done(done16), .err(err16)
  );

  // Expected architectural state of one ALU instance.
  typedef struct {
    logic [31:0] result, hi, lo, p_hi, p_lo;
    bit          zero, ovf, done, err;
    int          left;   // cycles until a pending MULT/DIV completes
  } mstate_t;

  mstate_t m32, m16;
  int      n_checks = 0;
  int      n_errs = 0;
  bit      cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int w);
    logic [63:0] u;
    u = {32'b0, v};
    if (v[w-1]) u = u - (64'd1 << w);
    return longint'(u);
  endfunction

  // One clock edge of the model: plain signed arithmetic on w-bit values.
  function automatic mstate_t step(input mstate_t s0, input int w, input bit en, input bit rst,
                                   input bit st, input logic [3:0] c,
                                   input logic [31:0] av0, input logic [31:0] bv0);
    mstate_t     s;
    logic [31:0] mask, av, bv;
    logic [63:0] p;
    longint      sa, sb, r, mx, mn;
    s    = s0;
    mask = 32'((64'd1 << w) - 1);
    av   = av0 & mask;
    bv   = bv0 & mask;
    sa   = sx(av, w);
    sb   = sx(bv, w);
    mx   = (longint'(1) << (w - 1)) - 1;
    mn   = -(longint'(1) << (w - 1));
    if (rst) begin
      s.result = '0; s.zero = 1'b1; s.ovf = 1'b0; s.hi = '0; s.lo = '0;
      s.done = 1'b0; s.err = 1'b0; s.left = 0;
      return s;
    end
    s.done = 1'b0;
    s.err  = 1'b0;
    if (s.left > 0) begin
      s.left--;
      if (s.left == 0) begin
        s.done = 1'b1; s.hi = s.p_hi; s.lo = s.p_lo;
      end
      return s;
    end
    if (!st) return s;
    if (en && (c == ALU_MULT || c == ALU_DIV)) begin
      if (c == ALU_DIV && sb == 0) begin
        s.hi = av; s.lo = mask; s.done = 1'b1; s.err = 1'b1;
        return s;
      end
      if (c == ALU_MULT) begin
        p      = 64'(sa * sb);
        s.p_lo = 32'(p) & mask;
        s.p_hi = 32'(p >> w) & mask;
      end else begin
        s.p_lo = 32'(sa / sb) & mask;
        s.p_hi = 32'(sa % sb) & mask;
      end
      s.left = w + 1;
      return s;
    end
    s.done = 1'b1;
    s.ovf  = 1'b0;
    case (c)
      ALU_AND:  s.result = av & bv;
      ALU_OR:   s.result = av | bv;
      ALU_NOR:  s.result = ~(av | bv) & mask;
      ALU_ADD: begin r = sa + sb; s.result = 32'(r) & mask; s.ovf = (r > mx) || (r < mn); end
      ALU_SUB: begin r = sa - sb; s.result = 32'(r) & mask; s.ovf = (r > mx) || (r < mn); end
      ALU_SLT:  s.result = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: s.result = (av < bv) ? 32'd1 : 32'd0;
      default: begin s.result = '0; s.err = 1'b1; end
    endcase
    s.zero = (s.result == '0);
    return s;
  endfunction

  // Model advances on the same edge that the DUTs sample their inputs.
  always @(posedge clk) begin
    m32 = step(m32, 32, 1'b1, reset, start, code, a_in, b_in);
    m16 = step(m16, 16, 1'b0, reset, start, code, a_in, b_in);
    cmp_en = 1'b1;
  end

  // Compare every output of both instances on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("r32", r32, m32.result);
      check("zero32", z32, m32.zero);
      check("ovf32", o32, m32.ovf);
      check("hi32", hi32, m32.hi);
      check("lo32", lo32, m32.lo);
      check("busy32", busy32, (m32.left > 0));
      check("done32", done32, m32.done);
      check("err32", err32, m32.err);
      check("r16", {16'b0, r16}, m16.result);
      check("zero16", z16, m16.zero);
      check("ovf16", o16, m16.ovf);
      check("hi16", {16'b0, hi16}, m16.hi);
      check("lo16", {16'b0, lo16}, m16.lo);
      check("busy16", busy16, (m16.left > 0));
      check("done16", done16, m16.done);
      check("err16", err16, m16.err);
    end
  end

  // Issue one start at a falling edge; returns one cycle after accept.
  task automatic op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; code = c; a_in = x; b_in = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done32(output int k);
    k = 1;
    while (!done32 && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_7FFF;
      5:       return 32'hFFFF_8000;
      6:       return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] codes [12] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_NOR,
                             ALU_MULT, ALU_DIV, 4'b0100, 4'b1111, 4'b1010};

  initial begin
    int k;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_zero", z32, 1'b1);
    check("rst_result", r32, 32'h0);
    check("rst_busy", busy32, 1'b0);
    reset = 1'b0;

    op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    check("add_res", r32, 32'h8000_0000);
    check("add_ovf", o32, 1'b1);
    check("add_zero", z32, 1'b0);
    check("add_done", done32, 1'b1);
    op(ALU_SUB, 32'd5, 32'd5);
    check("sub_res", r32, 32'h0);
    check("sub_zero", z32, 1'b1);
    check("sub_ovf", o32, 1'b0);
    op(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    check("slt_res", r32, 32'd1);
    op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    check("sltu_res", r32, 32'd0);
    op(ALU_NOR, 32'h0, 32'h0);
    check("nor_res", r32, 32'hFFFF_FFFF);
    op(4'b1111, 32'd3, 32'd4);
    check("ill_err", err32, 1'b1);
    check("ill_done", done32, 1'b1);
    check("ill_res", r32, 32'h0);

    // MULT -3*7 with a stray start at cycle 5 that must be ignored.
    op(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
    check("m16_mult_illegal_err", err16, 1'b1);
    check("mult_busy_c1", busy32, 1'b1);
    k = 1;
    while (!done32 && k < 60) begin
      start = (k == 4); code = ALU_ADD; a_in = 32'd1; b_in = 32'd1;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("mult_latency", k, 34);
    check("mult_hi", hi32, 32'hFFFF_FFFF);
    check("mult_lo", lo32, 32'hFFFF_FFEB);
    check("mult_busy_end", busy32, 1'b0);
    check("mult_result_kept", r32, 32'h0);

    op(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done32(k);
    check("div_latency", k, 34);
    check("div_lo", lo32, 32'hFFFF_FFFD);
    check("div_hi", hi32, 32'hFFFF_FFFF);
    op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done32(k);
    check("divmin_lo", lo32, 32'h8000_0000);
    check("divmin_hi", hi32, 32'h0);
    check("divmin_err", err32, 1'b0);
    op(ALU_DIV, 32'd9, 32'd0);
    check("div0_done", done32, 1'b1);
    check("div0_err", err32, 1'b1);
    check("div0_hi", hi32, 32'd9);
    check("div0_lo", lo32, 32'hFFFF_FFFF);
    check("div0_busy", busy32, 1'b0);

    // Reset in the middle of a MULT discards it.
    op(ALU_MULT, 32'd12345, 32'd678);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_busy", busy32, 1'b0);
    check("rstmid_hi", hi32, 32'h0);
    check("rstmid_lo", lo32, 32'h0);
    check("rstmid_done", done32, 1'b0);
    repeat (40) @(negedge clk);
    op(ALU_ADD, 32'd2, 32'd3);
    check("post_rst_add", r32, 32'd5);

    // Randomised traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) != 0);
      code  = codes[$urandom_range(0, 11)];
      a_in  = pick();
      b_in  = pick();
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
